// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO result unit: FSM state encodings and default data width.
package hilo_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } hilo_state_e;

endpackage

// File: rtl/hilo_unit_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the remainder
// and subtract the divisor if it fits, producing the next quotient bit.
module hilo_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    shifted  = {rem, q[WIDTH-1]};
    diff     = shifted - {1'b0, dvsr};
    ge       = (shifted >= {1'b0, dvsr});
    rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with multu write-back, mthi/mtlo moves and a WIDTH-cycle
// iterative restoring divider (divu/div) that holds busy while it runs.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic             wr_mult,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_by_zero
);

  hilo_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             signed_reg;
  logic [WIDTH-1:0] q_reg, rem_reg, dvsr_reg;
  logic             q_neg, r_neg;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_next, rem_next;

  // Operand magnitudes; unsigned operands pass through even with the MSB set.
  assign a_mag = (signed_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign b_mag = (signed_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;

  hilo_unit_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .q        (q_reg),
    .dvsr     (dvsr_reg),
    .rem_next (rem_next),
    .q_next   (q_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      signed_reg  <= 1'b0;
      q_reg       <= '0;
      rem_reg     <= '0;
      dvsr_reg    <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            a_reg       <= dividend;
            b_reg       <= divisor;
            signed_reg  <= div_signed;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= PREP;
          end else if (wr_mult) begin
            hi <= alu_hi;
            lo <= alu_lo;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        PREP: begin
          q_reg    <= a_mag;
          dvsr_reg <= b_mag;
          rem_reg  <= '0;
          q_neg    <= signed_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          r_neg    <= signed_reg && a_reg[WIDTH-1];
          cnt      <= '0;
          state    <= ITER;
        end
        ITER: begin
          q_reg   <= q_next;
          rem_reg <= rem_next;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // A zero divisor reports all-ones quotient and the untouched dividend.
          if (dvsr_reg == '0) begin
            lo          <= '1;
            hi          <= a_reg;
            div_by_zero <= 1'b1;
          end else begin
            lo <= q_neg ? -q_reg : q_reg;
            hi <= r_neg ? -rem_reg : rem_reg;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: the driver pushes model results, a monitor pops them
// when a division completes (busy falls) or a register write lands.
module tb_hilo_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  alu_lo, alu_hi, wdata, dividend, divisor;
  logic          wr_mult, mthi, mtlo, div_start, div_signed;
  logic [W-1:0]  hi, lo;
  logic          busy, div_by_zero;

  always #5 clk = ~clk;

  hilo_unit dut (
    .clk         (clk),
    .rst         (rst),
    .alu_lo      (alu_lo),
    .alu_hi      (alu_hi),
    .wr_mult     (wr_mult),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    string        name;
  } exp_t;

  exp_t div_q[$];
  exp_t wr_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0] m_hi, m_lo;
  logic         m_dbz;
  bit           wr_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; signed done in 64-bit so -2^31/-1 wraps naturally.
  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit s, input string name);
    exp_t   e;
    longint sa, sb, qq, rr;
    e.name = name;
    if (b == 0) begin
      e.lo  = '1;
      e.hi  = a;
      e.dbz = 1'b1;
    end else if (s) begin
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      qq    = sa / sb;
      rr    = sa % sb;
      e.lo  = qq[W-1:0];
      e.hi  = rr[W-1:0];
      e.dbz = 1'b0;
    end else begin
      e.lo  = a / b;
      e.hi  = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor
  int   busy_cnt  = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        if (div_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_div_result: got hi=0x%0h lo=0x%0h with no pending division", hi, lo);
        end else begin
          mon_e = div_q.pop_front();
          check({mon_e.name, " lo"}, lo, mon_e.lo);
          check({mon_e.name, " hi"}, hi, mon_e.hi);
          check({mon_e.name, " div_by_zero"}, div_by_zero, mon_e.dbz);
          check({mon_e.name, " busy_cycles"}, busy_cnt, 34);
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
      if (wr_pending) begin
        mon_e = wr_q.pop_front();
        check({mon_e.name, " hi"}, hi, mon_e.hi);
        check({mon_e.name, " lo"}, lo, mon_e.lo);
        check({mon_e.name, " div_by_zero"}, div_by_zero, mon_e.dbz);
        check({mon_e.name, " busy"}, busy, 0);
        wr_pending = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles", t);
    end
  endtask

  task automatic do_write(input logic wm, input logic mh, input logic ml,
                          input logic [W-1:0] h_in, input logic [W-1:0] l_in,
                          input logic [W-1:0] wd, input string name);
    exp_t e;
    @(posedge clk); #1;
    wr_mult = wm; mthi = mh; mtlo = ml;
    alu_hi = h_in; alu_lo = l_in; wdata = wd;
    if (wm) begin
      m_hi = h_in;
      m_lo = l_in;
    end else begin
      if (mh) m_hi = wd;
      if (ml) m_lo = wd;
    end
    @(posedge clk); #1;
    wr_mult = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    e.hi = m_hi; e.lo = m_lo; e.dbz = m_dbz; e.name = name;
    wr_q.push_back(e);
    wr_pending = 1'b1;
    @(negedge clk);
  endtask

  // Runs one division; with noise set, every other command is pulsed mid-division.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input bit noise, input string name);
    exp_t e;
    int   t;
    wait_idle();
    @(posedge clk); #1;
    div_start = 1'b1; dividend = a; divisor = b; div_signed = s;
    e = ref_div(a, b, s, name);
    div_q.push_back(e);
    @(posedge clk); #1;
    div_start  = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
    div_signed = ~s;
    @(negedge clk);
    check({name, " busy_after_start"}, busy, 1);
    check({name, " dbz_clear_on_start"}, div_by_zero, 0);
    t = 0;
    while (busy && t < 100) begin
      if (noise && t == 5) begin
        wr_mult = 1'b1; mthi = 1'b1; mtlo = 1'b1; div_start = 1'b1;
        alu_hi = $urandom; alu_lo = $urandom; wdata = $urandom;
      end else begin
        wr_mult = 1'b0; mthi = 1'b0; mtlo = 1'b0; div_start = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    wr_mult = 1'b0; mthi = 1'b0; mtlo = 1'b0; div_start = 1'b0;
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s division_timeout: busy still 1 after %0d cycles", name, t);
    end
    m_hi = e.hi; m_lo = e.lo; m_dbz = e.dbz;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    wr_mult = 1'b0; mthi = 1'b0; mtlo = 1'b0; div_start = 1'b0; div_signed = 1'b0;
    alu_lo = '0; alu_hi = '0; wdata = '0; dividend = '0; divisor = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    do_write(1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0, "wr_mult");

    do_div(32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
    check("divu_100_7 lo_const", lo, 14);
    check("divu_100_7 hi_const", hi, 2);

    do_div(32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0, "div_m7_2");
    check("div_m7_2 lo_const", lo, 32'hFFFF_FFFD);
    check("div_m7_2 hi_const", hi, 32'hFFFF_FFFF);

    do_div(32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, "divu_m7_2");
    check("divu_m7_2 lo_const", lo, 32'h7FFF_FFFC);
    check("divu_m7_2 hi_const", hi, 1);

    do_div(32'd5, 32'd0, 1'b1, 1'b0, "div_5_0");
    check("div_5_0 lo_const", lo, 32'hFFFF_FFFF);
    check("div_5_0 hi_const", hi, 5);
    repeat (4) @(negedge clk);
    check("div_5_0 dbz_held", div_by_zero, 1);

    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_overflow");
    check("div_overflow lo_const", lo, 32'h8000_0000);
    check("div_overflow hi_const", hi, 0);

    do_write(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1234_5678, "mthi_only");
    do_write(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h9ABC_DEF0, "mtlo_only");

    do_div(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b1, "divu_noise");

    // Reset during iteration 10 of a division aborts it.
    wait_idle();
    @(posedge clk); #1;
    div_start = 1'b1; dividend = 32'd1000; divisor = 32'd3; div_signed = 1'b0;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort busy", busy, 0);
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    do_write(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'hA5A5_A5A5, "mthi_mtlo_both");

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      int           op;
      op = $urandom_range(0, 3);
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 20));
        3:       rb = -W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if (op < 3) begin
        do_div(ra, rb, bit'($urandom_range(0, 1)), bit'(op == 2), $sformatf("rnd_div%0d", i));
      end else begin
        do_write(1'(($urandom_range(0, 3)) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, $sformatf("rnd_wr%0d", i));
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard div_q empty", div_q.size(), 0);
    check("scoreboard wr_q empty", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
